mem_lsu: RTL and testbench

Load/store unit forming the MEM stage of the five-stage MIPS pipeline. It consumes the memory request that EX produces (effective address, ALU op, store data) and carries out the access on a req/gnt/rvalid data bus. It extracts and sign- or zero-extends load data, raises a pipeline stall while an access is outstanding, and holds the registered MEM/WB write-back outputs.

---
 rtl/mem_lsu_pkg.sv | 39 +++
 rtl/mem_lsu_lane.sv | 46 ++++
 rtl/mem_lsu.sv | 143 ++++++++++++++
 tb/tb_mem_lsu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM stage: op encodings, widths, FSM states.
package mem_lsu_pkg;

    localparam int          RegBus   = 32;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
        logic half, word;
        half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
        word = (op == EXE_LW_OP) || (op == EXE_SW_OP);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Big-endian byte-lane steering: byte enables, store replication, load extract/extend.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [7:0]        op,
    input  logic [1:0]        off,
    input  logic [RegBus-1:0] sdata,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        be,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] ldata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Pick the addressed byte/halfword; offset 0 lives in the most significant lane.
    always_comb begin
        case (off)
            2'd0:    rbyte = rdata[31:24];
            2'd1:    rbyte = rdata[23:16];
            2'd2:    rbyte = rdata[15:8];
            default: rbyte = rdata[7:0];
        endcase
        rhalf = off[1] ? rdata[15:0] : rdata[31:16];
    end

    // Per-op enables, replicated store data and extended load data.
    always_comb begin
        be    = 4'b0000;
        wdata = sdata;
        ldata = ZeroWord;
        case (op)
            EXE_LB_OP:  begin be = 4'b1000 >> off; ldata = {{24{rbyte[7]}}, rbyte}; end
            EXE_LBU_OP: begin be = 4'b1000 >> off; ldata = {24'h0, rbyte}; end
            EXE_LH_OP:  begin be = off[1] ? 4'b0011 : 4'b1100; ldata = {{16{rhalf[15]}}, rhalf}; end
            EXE_LHU_OP: begin be = off[1] ? 4'b0011 : 4'b1100; ldata = {16'h0, rhalf}; end
            EXE_LW_OP:  begin be = 4'b1111; ldata = rdata; end
            EXE_SB_OP:  begin be = 4'b1000 >> off; wdata = {4{sdata[7:0]}}; end
            EXE_SH_OP:  begin be = off[1] ? 4'b0011 : 4'b1100; wdata = {2{sdata[15:0]}}; end
            EXE_SW_OP:  begin be = 4'b1111; wdata = sdata; end
            default:    be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: req/gnt/rvalid bus access, stall generation, MEM/WB register.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              wreg_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              wreg_o,
    output logic [4:0]        waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_req_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    lsu_state_e  state;
    logic [7:0]  op_q;
    logic [1:0]  off_q;
    logic [4:0]  waddr_q;

    logic        ld_i, st_i, mis_i, accept, store_q;
    logic [7:0]  lane_op;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [DATA_W-1:0] lane_wdata, lane_ldata;

    // Decode the incoming op; the lane uses live inputs in IDLE, the held op afterwards.
    always_comb begin
        ld_i     = is_load(aluop_i);
        st_i     = is_store(aluop_i);
        mis_i    = misaligned(aluop_i, mem_addr_i[1:0]);
        accept   = (state == ST_IDLE) && valid_i && (ld_i || st_i) && !mis_i;
        store_q  = is_store(op_q);
        lane_op  = (state == ST_IDLE) ? aluop_i : op_q;
        lane_off = (state == ST_IDLE) ? mem_addr_i[1:0] : off_q;
    end

    mem_lsu_lane u_lane (
        .op    (lane_op),
        .off   (lane_off),
        .sdata (reg2_i),
        .rdata (bus_rdata_i),
        .be    (lane_be),
        .wdata (lane_wdata),
        .ldata (lane_ldata)
    );

    // Hold upstream while an access is being accepted or is still outstanding.
    always_comb begin
        stall_req_o = accept ||
                      ((state == ST_REQ) && !(store_q && bus_gnt_i)) ||
                      ((state == ST_WAIT) && !bus_rvalid_i);
    end

    // Access FSM with registered bus payload and MEM/WB outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= 8'h00;
            off_q       <= 2'b00;
            waddr_q     <= 5'd0;
            wreg_o      <= 1'b0;
            waddr_o     <= 5'd0;
            wdata_o     <= ZeroWord;
            adel_o      <= 1'b0;
            ades_o      <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= ZeroWord;
        end else begin
            adel_o <= 1'b0;
            ades_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!valid_i) begin
                        wreg_o  <= 1'b0;
                        waddr_o <= waddr_i;
                        wdata_o <= wdata_i;
                    end else if (!(ld_i || st_i)) begin
                        wreg_o  <= wreg_i;
                        waddr_o <= waddr_i;
                        wdata_o <= wdata_i;
                    end else if (mis_i) begin
                        // Address error: drop the write-back, flag the exception.
                        wreg_o <= 1'b0;
                        adel_o <= ld_i;
                        ades_o <= st_i;
                    end else begin
                        wreg_o      <= 1'b0;
                        op_q        <= aluop_i;
                        off_q       <= mem_addr_i[1:0];
                        waddr_q     <= waddr_i;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= st_i;
                        bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        bus_be_o    <= lane_be;
                        bus_wdata_o <= lane_wdata;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wreg_o <= 1'b0;
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        state     <= store_q ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid_i) begin
                        wreg_o  <= 1'b1;
                        waddr_o <= waddr_q;
                        wdata_o <= lane_ldata;
                        state   <= ST_IDLE;
                    end else begin
                        wreg_o <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu against a lane-arithmetic reference model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i;
    logic        wreg_i;
    logic [4:0]  waddr_i;
    logic        wreg_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stall_req_o, adel_o, ades_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wreg_i(wreg_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .wreg_o(wreg_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
        .adel_o(adel_o), .ades_o(ades_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, lanes counted from the MSB.
    function automatic int m_size(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 4;
    endfunction

    function automatic logic m_load(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic logic m_store(input logic [7:0] op);
        return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
    endfunction

    function automatic logic [3:0] m_be(input logic [7:0] op, input int off);
        int sz, v;
        sz = m_size(op);
        v  = ((1 << sz) - 1) << (4 - sz - off);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
        int sz;
        sz = m_size(op);
        if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ldata(input logic [7:0] op, input int off, input logic [31:0] r);
        int sz;
        logic [31:0] v;
        sz = m_size(op);
        v  = r >> (8 * (4 - sz - off));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == EXE_LB_OP && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == EXE_LH_OP && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One instruction from presentation to completion, checking every cycle.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [4:0] wa, input logic [31:0] wd, input int gd, input int rd,
                          input logic [31:0] rdata);
        int  sz, off;
        logic ld, st, mem, mis;
        ld  = m_load(op);
        st  = m_store(op);
        mem = ld || st;
        sz  = m_size(op);
        off = int'(addr[1:0]);
        mis = mem && ((off % sz) != 0);
        @(negedge clk);
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
        wreg_i = 1'b1; waddr_i = wa; wdata_i = wd; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        #1 chk("stall_accept", stall_req_o, mem && !mis);
        @(posedge clk); #1;
        if (!mem) begin
            chk("alu_wreg", wreg_o, 1'b1);
            chk("alu_waddr", waddr_o, wa);
            chk("alu_wdata", wdata_o, wd);
        end else if (mis) begin
            chk("mis_wreg", wreg_o, 1'b0);
            chk("mis_adel", adel_o, ld);
            chk("mis_ades", ades_o, st);
            chk("mis_req", bus_req_o, 1'b0);
            @(negedge clk); valid_i = 1'b0;
            #1 chk("mis_stall", stall_req_o, 1'b0);
            @(posedge clk); #1;
            chk("mis_pulse_end", {adel_o, ades_o}, 2'b00);
        end else begin
            chk("acc_wreg", wreg_o, 1'b0);
            for (int i = 0; i <= gd; i++) begin
                @(negedge clk);
                bus_gnt_i    = (i == gd);
                bus_rvalid_i = 1'($urandom_range(0, 1));
                bus_rdata_i  = $urandom;
                #1 chk("req_stall", stall_req_o, !(st && i == gd));
                chk("req_req", bus_req_o, 1'b1);
                chk("req_we", bus_we_o, st);
                chk("req_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
                chk("req_be", bus_be_o, m_be(op, off));
                if (st) chk("req_wdata", bus_wdata_o, m_wdata(op, reg2));
                @(posedge clk); #1;
            end
            chk("post_gnt_req", bus_req_o, 1'b0);
            chk("post_gnt_wreg", wreg_o, 1'b0);
            if (ld) begin
                for (int j = 0; j <= rd; j++) begin
                    @(negedge clk);
                    bus_gnt_i    = 1'($urandom_range(0, 1));
                    bus_rvalid_i = (j == rd);
                    bus_rdata_i  = (j == rd) ? rdata : $urandom;
                    #1 chk("wait_stall", stall_req_o, j != rd);
                    @(posedge clk); #1;
                    if (j == rd) begin
                        chk("ld_wreg", wreg_o, 1'b1);
                        chk("ld_waddr", waddr_o, wa);
                        chk("ld_wdata", wdata_o, m_ldata(op, off, rdata));
                    end else begin
                        chk("wait_wreg", wreg_o, 1'b0);
                    end
                end
            end
        end
        @(negedge clk);
        valid_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    endtask

    logic [7:0] ops [9];

    initial begin
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, ADD_OP};
        rst = 1'b1; valid_i = 1'b0; aluop_i = 8'h00; mem_addr_i = 32'h0; reg2_i = 32'h0;
        wreg_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_wreg", wreg_o, 1'b0);
        chk("rst_waddr", waddr_o, 5'd0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_bus", {bus_req_o, bus_we_o, bus_be_o}, 6'h0);
        chk("rst_baddr", bus_addr_o, 32'h0);
        chk("rst_bwdata", bus_wdata_o, 32'h0);
        chk("rst_exc", {adel_o, ades_o}, 2'b00);
        chk("rst_stall", stall_req_o, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Directed cases.
        run_op(EXE_LW_OP,  32'h0000_0100, 32'h0, 5'd3, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_op(EXE_LB_OP,  32'h0000_0101, 32'h0, 5'd4, 32'h0, 0, 0, 32'h12F4_5678);
        run_op(EXE_LBU_OP, 32'h0000_0101, 32'h0, 5'd5, 32'h0, 1, 2, 32'h12F4_5678);
        run_op(EXE_SH_OP,  32'h0000_0202, 32'h0000_ABCD, 5'd0, 32'h0, 0, 0, 32'h0);
        run_op(EXE_SW_OP,  32'h0000_0300, 32'h1234_5678, 5'd0, 32'h0, 3, 0, 32'h0);
        run_op(EXE_LW_OP,  32'h0000_0102, 32'h0, 5'd6, 32'h0, 0, 0, 32'h0);
        run_op(EXE_SH_OP,  32'h0000_0203, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);
        run_op(ADD_OP,     32'h0, 32'h0, 5'd7, 32'h0000_0777, 0, 0, 32'h0);

        // Reset while waiting for read data, then a late rvalid.
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0400; waddr_i = 5'd9;
        @(posedge clk); #1;
        @(negedge clk); bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); bus_gnt_i = 1'b0; rst = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        chk("midrst_req", bus_req_o, 1'b0);
        chk("midrst_wreg", wreg_o, 1'b0);
        @(negedge clk); rst = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        #1 chk("late_rv_stall", stall_req_o, 1'b0);
        @(posedge clk); #1;
        chk("late_rv_wreg", wreg_o, 1'b0);
        @(negedge clk); bus_rvalid_i = 1'b0;
        run_op(ADD_OP, 32'h0, 32'h0, 5'd11, 32'h0000_1234, 0, 0, 32'h0);

        // Randomized mix of ops, alignments and bus latencies.
        for (int k = 0; k < 60; k++) begin
            run_op(ops[$urandom_range(0, 8)], $urandom, $urandom, 5'($urandom_range(1, 31)),
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
